sync_sequencer: RTL and testbench
=================================

SYNC_SEQUENCER -- requirements
Module: sync_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all delay, length and timeout counters.
REQ-002 SHALL have port clock  input  1  single clock for all logic; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  arm one acquisition cycle; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  return to IDLE from any state.
REQ-006 SHALL have port fg_opto  input  1  frame-grabber opto-coupler ready level; already synchronous to clock.
REQ-007 SHALL have port fg_open  input  1  frame-grabber shutter-open level; already synchronous to clock.
REQ-008 SHALL have port phase_in  input  1  phase reference signal; already synchronous to clock.
REQ-009 SHALL have port detector_busy  input  1  detector busy level.
REQ-010 SHALL have port cfg_phase_delay  input  CNT_W  cycles from phase front to trigger.
REQ-011 SHALL have port cfg_trigger_len  input  CNT_W  trigger pulse length in cycles.
REQ-012 SHALL have port cfg_busy_timeout  input  CNT_W  max cycles to wait for detector_busy rise.
REQ-013 SHALL have port trigger  output  1  detector trigger pulse.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on busy timeout.
REQ-016 SHALL have port state_out  output  8  current state code, zero-extended.

Function
REQ-017 SHALL encode states IDLE=0, FG_WAIT_OPTO=1, FG_WAIT_OPEN=2, WAIT_PHASE_FRONT=3, WAIT_PHASE_DELAY=4, TRIGGER_PROLONG=5, DETECTOR_BUSY=6, DETECTOR_WAIT=7, DETECTOR_FINISHED=8.
REQ-018 SHALL latch all three cfg_* inputs on the IDLE->FG_WAIT_OPTO transition; cfg changes mid-sequence have no effect.
REQ-019 SHALL go IDLE->FG_WAIT_OPTO when start=1; FG_WAIT_OPTO->FG_WAIT_OPEN when fg_opto=1; FG_WAIT_OPEN->WAIT_PHASE_FRONT when fg_open=1.
REQ-020 SHALL detect a phase front as phase_in=1 with the previous-cycle sample 0; the previous sample register updates every cycle in every state.
REQ-021 SHALL, on a phase front in WAIT_PHASE_FRONT, go to WAIT_PHASE_DELAY and remain exactly cfg_phase_delay cycles; delay 0 goes directly to TRIGGER_PROLONG.
REQ-022 SHALL ignore a phase_in already high on entry to WAIT_PHASE_FRONT until a new 0->1 edge.
REQ-023 SHALL remain in TRIGGER_PROLONG exactly max(cfg_trigger_len,1) cycles, then go to DETECTOR_BUSY.
REQ-024 SHALL drive trigger=1 exactly while state is TRIGGER_PROLONG, glitch-free (registered or decoded from registered state only).
REQ-025 SHALL go DETECTOR_BUSY->DETECTOR_WAIT when detector_busy=1; if it stays 0 for cfg_busy_timeout cycles, go to IDLE and pulse timeout_err for one cycle; timeout 0 disables the timeout.
REQ-026 SHALL go DETECTOR_WAIT->DETECTOR_FINISHED when detector_busy=0; DETECTOR_FINISHED lasts one cycle with done=1, then IDLE.
REQ-027 SHALL, on abort=1, go to IDLE next cycle from any state, drop trigger, and emit no done/timeout_err; abort wins over every other transition.
REQ-028 SHALL treat start and abort both high in IDLE as abort (stay IDLE).
REQ-029 SHALL use saturating-free countdown counters of CNT_W bits; no wrap-around reachable given REQ-021/023/025.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set state=IDLE, trigger=0, done=0, timeout_err=0, state_out=0, counters=0, phase sample=0; reset overrides abort and start.
REQ-031 SHALL apply reset mid-sequence (including during TRIGGER_PROLONG) with trigger low the cycle after the reset edge.

Structure
REQ-032 SHALL place the state enum type (8-bit base) and default CNT_W in shared package sync_pkg, also used by the self-test stimulus.
REQ-033 SHALL implement the counter as one sub-module sync_countdown (load, enable, zero flag), shared across delay, prolong and timeout phases.

Verification
REQ-034 Full cycle: delay=5, len=3, timeout=100, busy rises 4 cycles after trigger fall, held 10 -> state_out walks 0..8, trigger high 3 cycles starting 6 cycles after phase edge, done one pulse, back to 0.
REQ-035 Zero config: delay=0, len=0 -> trigger rises the cycle after the phase-edge cycle, lasts 1 cycle.
REQ-036 Timeout: timeout=20, busy never rises -> timeout_err pulse 20 cycles after DETECTOR_BUSY entry, state_out=0, no done.
REQ-037 Abort in WAIT_PHASE_DELAY (delay=50, abort at cycle 10) and in TRIGGER_PROLONG -> IDLE next cycle, trigger low, no done.
REQ-038 phase_in held high entering WAIT_PHASE_FRONT -> no advance until phase_in falls and rises again.
REQ-039 Reset asserted during DETECTOR_WAIT, and cfg changed mid-sequence -> all outputs 0 after reset edge; latched cfg values govern timing.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared types for the acquisition sequencer: state encoding and default counter width.
package sync_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [7:0] {
    ST_IDLE              = 8'd0,
    ST_FG_WAIT_OPTO      = 8'd1,
    ST_FG_WAIT_OPEN      = 8'd2,
    ST_WAIT_PHASE_FRONT  = 8'd3,
    ST_WAIT_PHASE_DELAY  = 8'd4,
    ST_TRIGGER_PROLONG   = 8'd5,
    ST_DETECTOR_BUSY     = 8'd6,
    ST_DETECTOR_WAIT     = 8'd7,
    ST_DETECTOR_FINISHED = 8'd8
  } state_e;

endpackage

// File: rtl/sync_countdown.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
module sync_countdown #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sync_sequencer.sv
// Frame-grabber / phase / detector acquisition sequencer with one shared countdown
// timer for phase delay, trigger length and detector-busy timeout.
module sync_sequencer
  import sync_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             fg_opto,
  input  logic             fg_open,
  input  logic             phase_in,
  input  logic             detector_busy,
  input  logic [CNT_W-1:0] cfg_phase_delay,
  input  logic [CNT_W-1:0] cfg_trigger_len,
  input  logic [CNT_W-1:0] cfg_busy_timeout,
  output logic             trigger,
  output logic             done,
  output logic             timeout_err,
  output logic [7:0]       state_out
);

  state_e           state_q;
  logic             phase_q;
  logic             trigger_q;
  logic             done_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] timeout_q;

  logic             front;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] len_val;
  logic [CNT_W-1:0] timeout_val;

  assign front = phase_in & ~phase_q;

  // Each phase loads N-1 and leaves on the zero flag, so it lasts exactly N cycles.
  assign len_val     = (len_q == '0)     ? '0 : len_q - CNT_W'(1);
  assign timeout_val = (timeout_q == '0) ? '0 : timeout_q - CNT_W'(1);

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_WAIT_PHASE_FRONT: begin
        if (front) begin
          cnt_load = 1'b1;
          cnt_val  = (delay_q == '0) ? len_val : delay_q - CNT_W'(1);
        end
      end
      ST_WAIT_PHASE_DELAY: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = len_val;
        end
      end
      ST_TRIGGER_PROLONG: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = timeout_val;
        end
      end
      default: ;
    endcase
  end

  assign cnt_en = (state_q == ST_WAIT_PHASE_DELAY) || (state_q == ST_TRIGGER_PROLONG) ||
                  (state_q == ST_DETECTOR_BUSY);

  sync_countdown #(
    .W (CNT_W)
  ) u_countdown (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // trigger_q is set exactly on the edges whose next state is TRIGGER_PROLONG.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= 1'b0;
      trigger_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      delay_q       <= '0;
      len_q         <= '0;
      timeout_q     <= '0;
    end else begin
      phase_q       <= phase_in;
      trigger_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              delay_q   <= cfg_phase_delay;
              len_q     <= cfg_trigger_len;
              timeout_q <= cfg_busy_timeout;
              state_q   <= ST_FG_WAIT_OPTO;
            end
          end
          ST_FG_WAIT_OPTO: if (fg_opto) state_q <= ST_FG_WAIT_OPEN;
          ST_FG_WAIT_OPEN: if (fg_open) state_q <= ST_WAIT_PHASE_FRONT;
          ST_WAIT_PHASE_FRONT: begin
            if (front) begin
              if (delay_q == '0) begin
                state_q   <= ST_TRIGGER_PROLONG;
                trigger_q <= 1'b1;
              end else begin
                state_q <= ST_WAIT_PHASE_DELAY;
              end
            end
          end
          ST_WAIT_PHASE_DELAY: begin
            if (cnt_zero) begin
              state_q   <= ST_TRIGGER_PROLONG;
              trigger_q <= 1'b1;
            end
          end
          ST_TRIGGER_PROLONG: begin
            if (cnt_zero) state_q <= ST_DETECTOR_BUSY;
            else          trigger_q <= 1'b1;
          end
          ST_DETECTOR_BUSY: begin
            if (detector_busy) begin
              state_q <= ST_DETECTOR_WAIT;
            end else if ((timeout_q != '0) && cnt_zero) begin
              state_q       <= ST_IDLE;
              timeout_err_q <= 1'b1;
            end
          end
          ST_DETECTOR_WAIT: begin
            if (!detector_busy) begin
              state_q <= ST_DETECTOR_FINISHED;
              done_q  <= 1'b1;
            end
          end
          ST_DETECTOR_FINISHED: state_q <= ST_IDLE;
          default:              state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign trigger     = trigger_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_sync_sequencer.sv
// Directed self-checking bench for sync_sequencer with hand-computed cycle counts.
module tb_sync_sequencer;
  import sync_pkg::*;

  localparam int unsigned W = CNT_W_DEF;

  logic         clock = 1'b0;
  logic         reset, start, abort, fg_opto, fg_open, phase_in, detector_busy;
  logic [W-1:0] cfg_phase_delay, cfg_trigger_len, cfg_busy_timeout;
  logic         trigger, done, timeout_err;
  logic [7:0]   state_out;

  int n_checks = 0;
  int n_fail   = 0;

  sync_sequencer #(
    .CNT_W (W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .fg_opto          (fg_opto),
    .fg_open          (fg_open),
    .phase_in         (phase_in),
    .detector_busy    (detector_busy),
    .cfg_phase_delay  (cfg_phase_delay),
    .cfg_trigger_len  (cfg_trigger_len),
    .cfg_busy_timeout (cfg_busy_timeout),
    .trigger          (trigger),
    .done             (done),
    .timeout_err      (timeout_err),
    .state_out        (state_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_cfg(input int d, input int l, input int t);
    cfg_phase_delay  = W'(d);
    cfg_trigger_len  = W'(l);
    cfg_busy_timeout = W'(t);
  endtask

  task automatic go_to_front();
    start = 1'b1;
    step(1);
    check("arm", 32'(state_out), 32'(ST_FG_WAIT_OPTO));
    start = 1'b0;
    step(2);
    check("opto_hold", 32'(state_out), 32'(ST_FG_WAIT_OPTO));
    fg_opto = 1'b1;
    step(1);
    check("opto", 32'(state_out), 32'(ST_FG_WAIT_OPEN));
    fg_opto = 1'b0;
    fg_open = 1'b1;
    step(1);
    check("open", 32'(state_out), 32'(ST_WAIT_PHASE_FRONT));
    fg_open = 1'b0;
  endtask

  task automatic count_until_trigger(input logic level, input int maxc, output int n);
    n = 0;
    while (trigger !== level && n < maxc) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    logic seen_done;

    reset = 1'b1; start = 1'b1; abort = 1'b1;
    fg_opto = 1'b0; fg_open = 1'b0; phase_in = 1'b0; detector_busy = 1'b0;
    set_cfg(0, 0, 0);
    step(2);
    check("rst_state", 32'(state_out), 32'(ST_IDLE));
    check("rst_trig", 32'(trigger), 0);
    check("rst_done", 32'(done), 0);
    check("rst_to", 32'(timeout_err), 0);
    reset = 1'b0;
    step(1);
    check("start_abort_idle", 32'(state_out), 32'(ST_IDLE));
    start = 1'b0; abort = 1'b0;

    // Full cycle
    set_cfg(5, 3, 100);
    go_to_front();
    phase_in = 1'b1;
    step(1);
    check("full_delay_entry", 32'(state_out), 32'(ST_WAIT_PHASE_DELAY));
    phase_in = 1'b0;
    count_until_trigger(1'b1, 200, n);
    check("full_trig_latency", 32'(n + 1), 6);
    check("full_prolong", 32'(state_out), 32'(ST_TRIGGER_PROLONG));
    count_until_trigger(1'b0, 200, n);
    check("full_trig_len", 32'(n), 3);
    check("full_busy", 32'(state_out), 32'(ST_DETECTOR_BUSY));
    step(3);
    detector_busy = 1'b1;
    step(1);
    check("full_wait", 32'(state_out), 32'(ST_DETECTOR_WAIT));
    step(9);
    check("full_wait_hold", 32'(state_out), 32'(ST_DETECTOR_WAIT));
    detector_busy = 1'b0;
    step(1);
    check("full_finished", 32'(state_out), 32'(ST_DETECTOR_FINISHED));
    check("full_done", 32'(done), 1);
    step(1);
    check("full_idle", 32'(state_out), 32'(ST_IDLE));
    check("full_done_drop", 32'(done), 0);

    // Zero config, timeout disabled
    set_cfg(0, 0, 0);
    go_to_front();
    phase_in = 1'b1;
    step(1);
    check("zero_trig", 32'(trigger), 1);
    check("zero_prolong", 32'(state_out), 32'(ST_TRIGGER_PROLONG));
    phase_in = 1'b0;
    step(1);
    check("zero_trig_len", 32'(trigger), 0);
    seen = 1'b0;
    repeat (40) begin
      step(1);
      seen |= timeout_err;
    end
    check("zero_no_timeout", 32'(seen), 0);
    check("zero_still_busy", 32'(state_out), 32'(ST_DETECTOR_BUSY));
    abort = 1'b1;
    step(1);
    check("zero_abort", 32'(state_out), 32'(ST_IDLE));
    abort = 1'b0;

    // Busy timeout
    set_cfg(0, 0, 20);
    go_to_front();
    phase_in = 1'b1;
    step(1);
    phase_in = 1'b0;
    step(1);
    check("to_busy", 32'(state_out), 32'(ST_DETECTOR_BUSY));
    n = 0;
    seen_done = 1'b0;
    while (!timeout_err && n < 100) begin
      step(1);
      n++;
      seen_done |= done;
    end
    check("to_latency", 32'(n), 20);
    check("to_idle", 32'(state_out), 32'(ST_IDLE));
    check("to_no_done", 32'(seen_done), 0);
    step(1);
    check("to_pulse", 32'(timeout_err), 0);

    // Abort during phase delay
    set_cfg(50, 1, 100);
    go_to_front();
    phase_in = 1'b1;
    step(1);
    phase_in = 1'b0;
    step(9);
    check("abd_in_delay", 32'(state_out), 32'(ST_WAIT_PHASE_DELAY));
    abort = 1'b1;
    step(1);
    check("abd_idle", 32'(state_out), 32'(ST_IDLE));
    abort = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      step(1);
      seen |= trigger | done;
    end
    check("abd_quiet", 32'(seen), 0);

    // Abort during trigger
    set_cfg(0, 10, 100);
    go_to_front();
    phase_in = 1'b1;
    step(1);
    check("abp_trig", 32'(trigger), 1);
    phase_in = 1'b0;
    step(2);
    abort = 1'b1;
    step(1);
    check("abp_trig_low", 32'(trigger), 0);
    check("abp_idle", 32'(state_out), 32'(ST_IDLE));
    check("abp_no_done", 32'(done), 0);
    abort = 1'b0;

    // phase_in already high on entry
    set_cfg(2, 1, 0);
    phase_in = 1'b1;
    go_to_front();
    step(5);
    check("ph_held", 32'(state_out), 32'(ST_WAIT_PHASE_FRONT));
    phase_in = 1'b0;
    step(1);
    check("ph_fall", 32'(state_out), 32'(ST_WAIT_PHASE_FRONT));
    phase_in = 1'b1;
    step(1);
    check("ph_rise", 32'(state_out), 32'(ST_WAIT_PHASE_DELAY));
    phase_in = 1'b0;
    abort = 1'b1;
    step(1);
    abort = 1'b0;

    // Reset during trigger
    set_cfg(0, 5, 0);
    go_to_front();
    phase_in = 1'b1;
    step(1);
    phase_in = 1'b0;
    step(1);
    check("rtp_trig_high", 32'(trigger), 1);
    reset = 1'b1;
    step(1);
    check("rtp_trig_low", 32'(trigger), 0);
    check("rtp_idle", 32'(state_out), 32'(ST_IDLE));
    reset = 1'b0;

    // cfg changed mid-sequence, then reset in DETECTOR_WAIT
    set_cfg(3, 2, 100);
    start = 1'b1;
    step(1);
    start = 1'b0;
    set_cfg(9, 9, 4);
    fg_opto = 1'b1;
    step(1);
    fg_opto = 1'b0;
    fg_open = 1'b1;
    step(1);
    fg_open = 1'b0;
    check("cfg_front", 32'(state_out), 32'(ST_WAIT_PHASE_FRONT));
    phase_in = 1'b1;
    count_until_trigger(1'b1, 200, n);
    check("cfg_delay", 32'(n), 4);
    phase_in = 1'b0;
    count_until_trigger(1'b0, 200, n);
    check("cfg_len", 32'(n), 2);
    step(6);
    check("cfg_timeout", 32'(state_out), 32'(ST_DETECTOR_BUSY));
    detector_busy = 1'b1;
    step(1);
    check("cfg_wait", 32'(state_out), 32'(ST_DETECTOR_WAIT));
    reset = 1'b1;
    step(1);
    check("rdw_state", 32'(state_out), 32'(ST_IDLE));
    check("rdw_trig", 32'(trigger), 0);
    check("rdw_done", 32'(done), 0);
    check("rdw_to", 32'(timeout_err), 0);
    reset = 1'b0;
    detector_busy = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
